// File: rtl/demux_14_collect_pkg.sv
// Shared constants and types for the 4-lane collector and its mux/tester neighbours.
//   LANES     : number of output lanes in a group
//   DEF_WIDTH : default beat/lane width shared with the upstream mux
//   lane_t    : lane index / fill pointer type
package demux_14_collect_pkg;

    localparam int unsigned LANES     = 4;
    localparam int unsigned DEF_WIDTH = 4;

    typedef logic [1:0] lane_t;

endpackage

// File: rtl/demux_14_collect_if.sv
// Stream-in / group-out bundle for demux_14_collect.
//   data_in, valid_in   : serialized beat from the upstream mux
//   flush, align        : commit partial group / restart at lane 0
//   data_0..3, valid_0..3, group_valid, fill_cnt : committed group and fill level
// master drives the stream and observes the group; slave is the collector.
interface demux_14_collect_if
    import demux_14_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             flush;
    logic             align;
    logic [WIDTH-1:0] data_0;
    logic [WIDTH-1:0] data_1;
    logic [WIDTH-1:0] data_2;
    logic [WIDTH-1:0] data_3;
    logic             valid_0;
    logic             valid_1;
    logic             valid_2;
    logic             valid_3;
    logic             group_valid;
    lane_t            fill_cnt;

    modport master (
        output data_in, valid_in, flush, align,
        input  data_0, data_1, data_2, data_3,
        input  valid_0, valid_1, valid_2, valid_3, group_valid, fill_cnt
    );

    modport slave (
        input  data_in, valid_in, flush, align,
        output data_0, data_1, data_2, data_3,
        output valid_0, valid_1, valid_2, valid_3, group_valid, fill_cnt
    );

endinterface

// File: rtl/demux_14_stage.sv
// One staging lane: holds a beat and its filled flag until the group commits.
//   clk, reset : clock, async active-high reset
//   we, d      : write d into the lane and mark it filled
//   clr        : empty the lane (write wins so align can refill lane 0 at once)
//   q, filled  : staged beat and filled flag
module demux_14_stage #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             filled
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q      <= '0;
            filled <= 1'b0;
        end else if (we) begin
            q      <= d;
            filled <= 1'b1;
        end else if (clr) begin
            q      <= '0;
            filled <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_14_collect.sv
// Reassembles a serialized beat stream into 4-lane groups, presented for one cycle per commit.
//   clk, reset : clock, async active-high reset
//   bus        : demux_14_collect_if slave (stream in, registered group out, fill_cnt)
// The 4th beat and a beat arriving with flush go straight to the output register and are
// never staged, so the next group can start in the very next cycle.
module demux_14_collect
    import demux_14_collect_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    demux_14_collect_if.slave    bus
);

    lane_t            ptr_q, ptr_d;
    logic [LANES-1:0] mask;
    logic [LANES-1:0] we;
    logic [LANES-1:0] beat_hit;
    logic             clr;
    logic             commit;
    logic [WIDTH-1:0] stage [LANES];

    logic [WIDTH-1:0] data_q  [LANES];
    logic [LANES-1:0] valid_q;
    logic             group_valid_q;

    always_comb begin
        beat_hit         = '0;
        beat_hit[ptr_q]  = bus.valid_in;
        // align overrides everything, including a simultaneous flush
        commit = !bus.align
            && ((bus.valid_in && (ptr_q == lane_t'(LANES - 1)))
                || (bus.flush && ((|mask) || bus.valid_in)));
        clr    = bus.align || commit;
        for (int k = 0; k < LANES; k++) begin
            if (bus.align) begin
                we[k] = bus.valid_in && (k == 0);
            end else begin
                we[k] = bus.valid_in && !commit && (ptr_q == lane_t'(k));
            end
        end
        ptr_d = ptr_q;
        if (bus.align) begin
            ptr_d = bus.valid_in ? lane_t'(1) : lane_t'(0);
        end else if (commit) begin
            ptr_d = '0;
        end else if (bus.valid_in) begin
            ptr_d = ptr_q + lane_t'(1);
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_stage
        demux_14_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk    (clk),
            .reset  (reset),
            .we     (we[g]),
            .clr    (clr),
            .d      (bus.data_in),
            .q      (stage[g]),
            .filled (mask[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q         <= '0;
            valid_q       <= '0;
            group_valid_q <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            group_valid_q <= commit;
            for (int k = 0; k < LANES; k++) begin
                valid_q[k] <= commit && (mask[k] || beat_hit[k]);
                if (commit) begin
                    if (mask[k]) begin
                        data_q[k] <= stage[k];
                    end else if (beat_hit[k]) begin
                        data_q[k] <= bus.data_in;
                    end else begin
                        data_q[k] <= '0;
                    end
                end
            end
        end
    end

    assign bus.data_0      = data_q[0];
    assign bus.data_1      = data_q[1];
    assign bus.data_2      = data_q[2];
    assign bus.data_3      = data_q[3];
    assign bus.valid_0     = valid_q[0];
    assign bus.valid_1     = valid_q[1];
    assign bus.valid_2     = valid_q[2];
    assign bus.valid_3     = valid_q[3];
    assign bus.group_valid = group_valid_q;
    assign bus.fill_cnt    = ptr_q;

endmodule

// File: tb/tb_demux_14_collect.sv
// Directed bench for demux_14_collect: a queue-based group model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_demux_14_collect;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic run   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    demux_14_collect_if #(.WIDTH(4)) bus ();

    demux_14_collect #(
        .WIDTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: the current partial group is just a queue of beats.
    int q[$];
    int m_data  [4];
    int m_valid [4];
    int m_gv;
    int m_cnt;

    task automatic model_clear();
        q.delete();
        for (int k = 0; k < 4; k++) begin
            m_data[k]  = 0;
            m_valid[k] = 0;
        end
        m_gv  = 0;
        m_cnt = 0;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            model_clear();
        end else begin
            m_gv = 0;
            for (int k = 0; k < 4; k++) m_valid[k] = 0;
            if (bus.align) begin
                q.delete();
                if (bus.valid_in) q.push_back(int'(bus.data_in));
            end else begin
                if (bus.valid_in) q.push_back(int'(bus.data_in));
                if (q.size() == 4 || (bus.flush && q.size() > 0)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (k < q.size()) begin
                            m_data[k]  = q[k];
                            m_valid[k] = 1;
                        end else begin
                            m_data[k] = 0;
                        end
                    end
                    m_gv = 1;
                    q.delete();
                end
            end
            m_cnt = q.size();
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run && !reset) begin
            chk("m.data_0", int'(bus.data_0), m_data[0]);
            chk("m.data_1", int'(bus.data_1), m_data[1]);
            chk("m.data_2", int'(bus.data_2), m_data[2]);
            chk("m.data_3", int'(bus.data_3), m_data[3]);
            chk("m.valid",  int'({bus.valid_0, bus.valid_1, bus.valid_2, bus.valid_3}),
                (m_valid[0] << 3) | (m_valid[1] << 2) | (m_valid[2] << 1) | m_valid[3]);
            chk("m.group_valid", int'(bus.group_valid), m_gv);
            chk("m.fill_cnt",    int'(bus.fill_cnt),    m_cnt);
        end
    end

    task automatic drive(input bit v, input int d, input bit f, input bit a);
        @(negedge clk);
        bus.valid_in = v;
        bus.data_in  = 4'(d);
        bus.flush    = f;
        bus.align    = a;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 1'b0);
    endtask

    // Let the edge that consumes the last driven inputs happen.
    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    function automatic int lanes();
        return int'({bus.data_0, bus.data_1, bus.data_2, bus.data_3});
    endfunction

    function automatic int valids();
        return int'({bus.valid_0, bus.valid_1, bus.valid_2, bus.valid_3});
    endfunction

    initial begin
        bus.valid_in = 1'b0;
        bus.data_in  = '0;
        bus.flush    = 1'b0;
        bus.align    = 1'b0;
        model_clear();

        // Reset state
        #2;
        chk("reset.data",  lanes(), 16'h0000);
        chk("reset.valid", valids() | int'(bus.group_valid), 0);
        chk("reset.fill",  int'(bus.fill_cnt), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;

        // Full group
        drive(1, 'h0, 0, 0);
        drive(1, 'hA, 0, 0);
        drive(1, 'h5, 0, 0);
        drive(1, 'hF, 0, 0);
        settle();
        chk("full.data",  lanes(), 16'h0A5F);
        chk("full.valid", valids(), 4'b1111);
        chk("full.gv",    int'(bus.group_valid), 1);
        idle();
        settle();
        chk("full.gv_pulse", int'(bus.group_valid), 0);
        chk("full.hold",     lanes(), 16'h0A5F);

        // Gapped beats
        for (int i = 1; i <= 4; i++) begin
            drive(1, i, 0, 0);
            settle();
            chk("gap.fill", int'(bus.fill_cnt), i % 4);
            idle();
        end
        chk("gap.data", lanes(), 16'h1234);

        // Flush partial
        drive(1, 7, 0, 0);
        drive(1, 8, 0, 0);
        drive(0, 0, 1, 0);
        settle();
        chk("flush.data",  lanes(), 16'h7800);
        chk("flush.valid", valids(), 4'b1100);
        chk("flush.gv",    int'(bus.group_valid), 1);
        chk("flush.fill",  int'(bus.fill_cnt), 0);

        // Flush together with a beat
        drive(1, 3, 0, 0);
        drive(1, 4, 0, 0);
        drive(1, 9, 1, 0);
        settle();
        chk("flushbeat.data",  lanes(), 16'h3490);
        chk("flushbeat.valid", valids(), 4'b1110);

        // Align mid-group
        drive(1, 'hB, 0, 0);
        drive(1, 'hC, 0, 0);
        drive(1, 'hD, 0, 1);
        settle();
        chk("align.fill", int'(bus.fill_cnt), 1);
        drive(1, 'hE, 0, 0);
        drive(1, 'hF, 0, 0);
        drive(1, 'h0, 0, 0);
        settle();
        chk("align.data",  lanes(), 16'hDEF0);
        chk("align.valid", valids(), 4'b1111);

        // Flush with an empty group is a no-op
        drive(0, 0, 1, 0);
        settle();
        chk("flushempty.gv", int'(bus.group_valid), 0);

        // Align beats flush; the beat lands in lane 0
        drive(1, 6, 1, 1);
        settle();
        chk("alignflush.gv",   int'(bus.group_valid), 0);
        chk("alignflush.fill", int'(bus.fill_cnt), 1);
        drive(0, 0, 1, 0);
        settle();
        chk("alignflush.data",  lanes(), 16'h6000);
        chk("alignflush.valid", valids(), 4'b1000);

        // Back-to-back groups with no bubble
        for (int i = 1; i <= 8; i++) drive(1, i, 0, 0);
        settle();
        chk("b2b.data", lanes(), 16'h5678);
        chk("b2b.gv",   int'(bus.group_valid), 1);
        idle();

        // Reset mid-group clears immediately; the partial group is lost
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        settle();
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("midreset.data", lanes(), 16'h0000);
        chk("midreset.fill", int'(bus.fill_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 1, 0);
        idle();
        idle();
        settle();
        chk("midreset.nocommit", int'(bus.group_valid), 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
